unified_mem: RTL and testbench
==============================

UNIFIED_MEM -- requirements
Module: unified_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; a power of two, at least 4.
REQ-002 SHALL have parameter WAIT_STATES, default 1: extra access cycles, 0..15.
REQ-003 SHALL have these ports, in this order:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- IorD  in  1  address select: 1 = alu_out, 0 = pc.
- MemWrite  in  1  store request.
- IRWrite  in  1  instruction fetch request.
- size  in  3  RV32I funct3 code: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- pc  in  32  byte address of the fetch.
- alu_out  in  32  byte address of the load/store.
- wdata  in  32  store data; right-aligned (data in the low-order bits).
- addr  out  32  combinational: IorD ? alu_out : pc.
- busy  out  1  high while an access is in flight.
- ack  out  1  one-cycle completion pulse.
- instruction  out  32  registered fetch result.
- rdata  out  32  registered load result, extended per size.
- misaligned  out  1  valid only in the ack cycle.
- oob  out  1  out-of-range flag; valid only in the ack cycle.

Function
REQ-004 SHALL use an FSM with three states:
- IDLE to WAIT on req when WAIT_STATES > 0.
- IDLE to ACCESS on req when WAIT_STATES = 0.
- WAIT to ACCESS after WAIT_STATES cycles, counted by a down-counter.
- ACCESS to IDLE unconditionally.
REQ-005 SHALL latch addr, size, MemWrite, IRWrite and wdata on the accepting edge; later input changes do not affect the access.
REQ-006 SHALL perform the access on the edge leaving ACCESS; ack, instruction, rdata and flags update on that edge.
- ack is therefore high exactly WAIT_STATES+2 cycles after the accepting edge.
REQ-007 SHALL drive busy high in WAIT and ACCESS and low in IDLE, including the ack cycle.
- A new req in the ack cycle is accepted, giving back-to-back accesses.
REQ-008 SHALL ignore req while busy.
REQ-009 SHALL use little-endian byte lanes:
- word index = addr[log2(DEPTH_WORDS)+1:2].
- Byte lane = addr[1:0].
- Halfword lane = addr[1].
REQ-010 SHALL complete loads as follows:
- lb/lh: sign-extend the selected lane into rdata.
- lbu/lhu: zero-extend the selected lane into rdata.
- lw: return the whole word.
REQ-011 SHALL complete stores as follows:
- sb/sh: write only the addressed lane(s) from the low bits of wdata; other bytes are preserved.
- sw: write the whole word.
REQ-012 SHALL complete a fetch (IRWrite) by loading the addressed word into instruction; rdata is unchanged.
REQ-013 SHALL give IRWrite priority when IRWrite and MemWrite are both latched: the fetch is performed and the store is dropped.
REQ-014 SHALL treat an access with neither IRWrite nor MemWrite as a load.
REQ-015 SHALL treat size 011, 110 or 111 (and 100/101 on a store) as a no-op:
- memory, rdata and instruction are unchanged.
- ack still pulses.
REQ-016 SHALL treat a latched address >= 4*DEPTH_WORDS as out of range:
- stores are dropped.
- loads return rdata = 0.
- fetches return instruction = 0.
- oob = 1 in the ack cycle.
REQ-017 SHALL hold instruction and rdata between accesses, and drive misaligned and oob low outside the ack cycle.

Reset
REQ-018 SHALL, on reset high at a clock edge, set:
- state IDLE and wait counter 0.
- busy, ack, misaligned and oob to 0.
- instruction and rdata to 0.
REQ-019 SHALL, on reset during WAIT or ACCESS, abort the access: a pending store is discarded and no ack is issued.
REQ-020 SHALL never clear memory contents on reset.

Configuration
REQ-021 With UNIFIED_MEM_MISALIGN_EXC_EN defined, SHALL handle these as misaligned: fetch or lw/sw with addr[1:0] != 0, and lh/lhu/sh with addr[0] = 1.
- The access performs no memory write.
- rdata and instruction are unchanged.
- ack = 1 and misaligned = 1 in the ack cycle.
REQ-022 Without UNIFIED_MEM_MISALIGN_EXC_EN, SHALL force the offending low address bits to 0 (truncating alignment), and tie misaligned to 0.

Structure
REQ-023 SHALL take the following from package unified_mem_pkg:
- size-code localparams.
- the FSM state enum.
- WAIT_W = 4.
REQ-024 SHALL place lane extraction, store-merge and the misalign check in combinational sub-module unified_mem_lane, instantiated once.

Verification
REQ-025 Bench SHALL cover these scenarios with WAIT_STATES=1:
- Back-to-back: sw 0xDEADBEEF @0x10, then lw @0x10 -> rdata = 0xDEADBEEF, each ack exactly 3 cycles after its accepting edge, second req issued in the first ack cycle.
- Byte lanes: sb 0x80 @0x13 over 0x11223344 -> word = 0x80223344; lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080; lhu @0x12 -> 0x00008022.
- Fetch priority: IRWrite = MemWrite = 1, IorD=0, pc = 0x0 -> instruction = mem[0], memory unchanged, rdata unchanged.
- Misaligned/range: lw @0x22 -> with macro misaligned = 1, rdata unchanged; without macro reads word @0x20. Address 4*DEPTH_WORDS -> oob = 1, rdata = 0.
- Reset mid-access: sw issued, reset asserted in WAIT -> no ack, busy = 0, target word unchanged on later lw.

Source files
------------

// File: rtl/unified_mem_pkg.sv
// Shared definitions for the unified instruction/data memory: RV32I size
// codes, FSM state encoding, latched-request record and the wait-counter width.
package unified_mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // Everything the access needs, captured on the accepting edge.
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        mem_write;
        logic        ir_write;
        logic [31:0] wdata;
    } mem_req_t;

    // Loads accept all five codes; stores only the signed-name codes.
    function automatic logic size_valid(input logic [2:0] sz, input logic is_store);
        case (sz)
            SZ_B, SZ_H, SZ_W: size_valid = 1'b1;
            SZ_BU, SZ_HU:     size_valid = ~is_store;
            default:          size_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/unified_mem_lane.sv
// Byte-lane datapath for unified_mem: load extraction with sign/zero
// extension, store merge into the current word, and alignment handling.
// UNIFIED_MEM_MISALIGN_EXC_EN: flag misaligned accesses instead of
// truncating the low address bits.
module unified_mem_lane
    import unified_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  size,
    input  logic        is_fetch,
    input  logic        is_store,
    input  logic [31:0] wdata,
    output logic        op_valid,
    output logic        misaligned,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [1:0]  off;
    logic [7:0]  b;
    logic [15:0] h;

    // Alignment, lane selection, load extension and store merge.
    always_comb begin
        // A fetch is always a full word, whatever size says.
        op_valid   = is_fetch | size_valid(size, is_store);
        off        = byte_off;
        misaligned = 1'b0;
`ifdef UNIFIED_MEM_MISALIGN_EXC_EN
        if (op_valid) begin
            if (is_fetch || size == SZ_W)
                misaligned = (byte_off != 2'b00);
            else if (size == SZ_H || size == SZ_HU)
                misaligned = byte_off[0];
        end
`else
        if (is_fetch || size == SZ_W)
            off = 2'b00;
        else if (size == SZ_H || size == SZ_HU)
            off[0] = 1'b0;
`endif
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];

        case (size)
            SZ_B:    load_data = {{24{b[7]}}, b};
            SZ_H:    load_data = {{16{h[15]}}, h};
            SZ_BU:   load_data = {24'd0, b};
            SZ_HU:   load_data = {16'd0, h};
            default: load_data = word;
        endcase

        merged = word;
        case (size)
            SZ_B: merged[{off, 3'b000} +: 8] = wdata[7:0];
            SZ_H: begin
                if (off[1]) merged[31:16] = wdata[15:0];
                else        merged[15:0]  = wdata[15:0];
            end
            SZ_W:    merged = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/unified_mem.sv
// Unified instruction/data memory with a multi-cycle access FSM
// (IDLE -> WAIT -> ACCESS -> IDLE). Requests are latched on acceptance;
// the access itself happens on the edge leaving ACCESS, which also raises ack.
// Optional build macro: UNIFIED_MEM_MISALIGN_EXC_EN (report misaligned
// accesses instead of truncating alignment).
module unified_mem
    import unified_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        IorD,
    input  logic        MemWrite,
    input  logic        IRWrite,
    input  logic [2:0]  size,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] wdata,
    output logic [31:0] addr,
    output logic        busy,
    output logic        ack,
    output logic [31:0] instruction,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        oob
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    mem_req_t          r;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic          in_range;
    logic          is_fetch;
    logic          is_store;
    logic          op_valid;
    logic          lane_mis;
    logic [31:0]   load_data;
    logic [31:0]   merged;
    logic          do_store;

    assign addr     = IorD ? alu_out : pc;
    assign idx      = r.addr[AW+1:2];
    assign in_range = (r.addr >> (AW + 2)) == 32'd0;
    // Fetch wins over store; neither means load.
    assign is_fetch = r.ir_write;
    assign is_store = r.mem_write & ~r.ir_write;
    assign word     = mem[idx];
    assign do_store = is_store & op_valid & ~lane_mis & in_range;

    unified_mem_lane u_lane (
        .word       (word),
        .byte_off   (r.addr[1:0]),
        .size       (r.size),
        .is_fetch   (is_fetch),
        .is_store   (is_store),
        .wdata      (r.wdata),
        .op_valid   (op_valid),
        .misaligned (lane_mis),
        .load_data  (load_data),
        .merged     (merged)
    );

    // Memory write on the edge leaving ACCESS; reset aborts it, never clears contents.
    always_ff @(posedge clk) begin
        if (!reset && state == S_ACCESS && do_store)
            mem[idx] <= merged;
    end

    // Access FSM with registered handshake, flags and read results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            busy        <= 1'b0;
            ack         <= 1'b0;
            misaligned  <= 1'b0;
            oob         <= 1'b0;
            instruction <= '0;
            rdata       <= '0;
        end else begin
            ack        <= 1'b0;
            misaligned <= 1'b0;
            oob        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        r.addr      <= addr;
                        r.size      <= size;
                        r.mem_write <= MemWrite;
                        r.ir_write  <= IRWrite;
                        r.wdata     <= wdata;
                        busy        <= 1'b1;
                        if (WAIT_STATES > 0) begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_W'(WAIT_STATES);
                        end else begin
                            state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt <= WAIT_W'(1)) begin
                        state    <= S_ACCESS;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                S_ACCESS: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    ack        <= 1'b1;
                    misaligned <= lane_mis;
                    oob        <= ~in_range;
                    if (op_valid && !lane_mis) begin
                        if (is_fetch)
                            instruction <= in_range ? word : 32'd0;
                        else if (!is_store)
                            rdata <= in_range ? load_data : 32'd0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem.sv
// Self-checking bench for unified_mem: directed vector table, reset-abort
// sequence, then random accesses against a byte-array reference model.
module tb_unified_mem;

    localparam int DEPTH = 64;
    localparam int WS    = 1;
    localparam int MEMB  = 4 * DEPTH;

`ifdef UNIFIED_MEM_MISALIGN_EXC_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, req, IorD, MemWrite, IRWrite;
    logic [2:0]  size;
    logic [31:0] pc, alu_out, wdata;
    logic [31:0] addr, instruction, rdata;
    logic        busy, ack, misaligned, oob;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    unified_mem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .req(req), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .size(size), .pc(pc), .alu_out(alu_out), .wdata(wdata),
        .addr(addr), .busy(busy), .ack(ack), .instruction(instruction),
        .rdata(rdata), .misaligned(misaligned), .oob(oob)
    );

    // Reference model state: memory as bytes, plus last read results.
    logic [7:0]  mref [MEMB];
    logic [31:0] exp_rdata = 32'd0;
    logic [31:0] exp_instr = 32'd0;

    typedef struct {
        string       name;
        bit          ir, we, iord;
        logic [2:0]  sz;
        logic [31:0] a, wd, e_rdata, e_instr;
        bit          e_mis, e_oob;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] gather(input logic [31:0] aa, input int n);
        logic [63:0] g = 64'd0;
        for (int i = 0; i < n; i++) g |= 64'(mref[aa + 32'(i)]) << (8 * i);
        return g;
    endfunction

    // Reference behaviour computed directly from the access rules.
    task automatic model(input bit ir, input bit we, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output bit emis, output bit eoob);
        int n = 4;
        bit valid = 1'b1, sgn = 1'b0, store;
        logic [31:0] aa;
        logic [63:0] v;
        store = we && !ir;
        if (!ir) begin
            case (sz)
                3'd0: begin n = 1; sgn = 1'b1; end
                3'd1: begin n = 2; sgn = 1'b1; end
                3'd2: n = 4;
                3'd4: begin n = 1; valid = !store; end
                3'd5: begin n = 2; valid = !store; end
                default: valid = 1'b0;
            endcase
        end
        eoob = (a >= 32'(MEMB));
        emis = 1'b0;
        aa   = a;
        if (valid && (a % 32'(n)) != 0) begin
            if (MIS_EN) emis = 1'b1;
            else        aa = a - (a % 32'(n));
        end
        if (!valid || emis) return;
        if (ir) begin
            exp_instr = eoob ? 32'd0 : gather(aa, 4)[31:0];
        end else if (store) begin
            if (!eoob) for (int i = 0; i < n; i++) mref[aa + 32'(i)] = wd[8*i +: 8];
        end else if (eoob) begin
            exp_rdata = 32'd0;
        end else begin
            v = gather(aa, n);
            if (sgn && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
            exp_rdata = v[31:0];
        end
    endtask

    // Issue one request, hold garbage (with req high) while busy, wait for ack.
    // ack rises on the (WS+1)th edge after acceptance: high in the (WS+2)th cycle.
    task automatic access(input bit ir, input bit we, input bit iord,
                          input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int k = 0;
        bit got = 1'b0;
        req = 1'b1; IRWrite = ir; MemWrite = we; IorD = iord; size = sz; wdata = wd;
        if (iord) begin alu_out = a; pc = $urandom; end
        else      begin pc = a; alu_out = $urandom; end
        #1;
        chk("addr_mux", addr, a);
        @(posedge clk); #1;
        chk("busy_inflight", {busy, ack, misaligned, oob}, 32'b1000);
        IRWrite = 1'($urandom); MemWrite = 1'($urandom); IorD = 1'($urandom);
        size = 3'($urandom); pc = $urandom; alu_out = $urandom; wdata = $urandom;
        while (k < 8 && !got) begin
            @(posedge clk); #1;
            k++;
            got = ack;
        end
        req = 1'b0;
        chk("ack_latency", 32'(k), 32'(WS + 1));
        chk("busy_in_ack", busy, 1'b0);
    endtask

    task automatic rand_op(input bit ir, input bit we, input bit iord,
                           input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        bit emis, eoob;
        access(ir, we, iord, sz, a, wd);
        model(ir, we, sz, a, wd, emis, eoob);
        chk("rnd_rdata", rdata, exp_rdata);
        chk("rnd_instr", instruction, exp_instr);
        chk("rnd_mis", misaligned, emis);
        chk("rnd_oob", oob, eoob);
    endtask

    task automatic addv(input string nm, input bit ir, input bit we, input bit iord,
                        input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic [31:0] ei, input bit em, input bit eo);
        vec_t v;
        v.name = nm; v.ir = ir; v.we = we; v.iord = iord; v.sz = sz; v.a = a; v.wd = wd;
        v.e_rdata = er; v.e_instr = ei; v.e_mis = em; v.e_oob = eo;
        vq.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seen, emis, eoob;
        logic [31:0] r13, r15, a;
        reset = 1'b1; req = 1'b0; IorD = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
        size = 3'd0; pc = 32'd0; alu_out = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_mis", misaligned, 1'b0);
        chk("rst_oob", oob, 1'b0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b0;

        // Known contents everywhere so the model starts in step.
        for (int w = 0; w < DEPTH; w++) rand_op(1'b0, 1'b1, 1'b1, 3'b010, 32'(4 * w), 32'd0);

        // Directed table; every row is issued in the previous row's ack cycle.
        r13 = MIS_EN ? 32'h00500093 : 32'h12345678;
        r15 = MIS_EN ? 32'h00000000 : 32'h00003344;
        addv("sw_beef",   0, 1, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        32'h0,        0, 0);
        addv("lw_beef",   0, 0, 1, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 32'h0,        0, 0);
        addv("sw_1122",   0, 1, 1, 3'b010, 32'h10,  32'h11223344, 32'hDEADBEEF, 32'h0,        0, 0);
        addv("sb_80",     0, 1, 1, 3'b000, 32'h13,  32'hFFFFFF80, 32'hDEADBEEF, 32'h0,        0, 0);
        addv("lw_merged", 0, 0, 1, 3'b010, 32'h10,  32'h0,        32'h80223344, 32'h0,        0, 0);
        addv("lb_13",     0, 0, 1, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 32'h0,        0, 0);
        addv("lbu_13",    0, 0, 1, 3'b100, 32'h13,  32'h0,        32'h00000080, 32'h0,        0, 0);
        addv("lhu_12",    0, 0, 1, 3'b101, 32'h12,  32'h0,        32'h00008022, 32'h0,        0, 0);
        addv("sw_insn",   0, 1, 1, 3'b010, 32'h0,   32'h00500093, 32'h00008022, 32'h0,        0, 0);
        addv("fetch_pri", 1, 1, 0, 3'b010, 32'h0,   32'hCAFEF00D, 32'h00008022, 32'h00500093, 0, 0);
        addv("lw_0",      0, 0, 1, 3'b010, 32'h0,   32'h0,        32'h00500093, 32'h00500093, 0, 0);
        addv("sw_20",     0, 1, 1, 3'b010, 32'h20,  32'h12345678, 32'h00500093, 32'h00500093, 0, 0);
        addv("lw_22",     0, 0, 1, 3'b010, 32'h22,  32'h0,        r13,          32'h00500093, MIS_EN, 0);
        addv("lw_oob",    0, 0, 1, 3'b010, 32'h100, 32'h0,        32'h0,        32'h00500093, 0, 1);
        addv("lh_11",     0, 0, 1, 3'b001, 32'h11,  32'h0,        r15,          32'h00500093, MIS_EN, 0);
        addv("fetch_oob", 1, 0, 0, 3'b010, 32'h100, 32'h0,        r15,          32'h0,        0, 1);
        addv("size_011",  0, 0, 1, 3'b011, 32'h10,  32'h0,        r15,          32'h0,        0, 0);
        addv("lw_10",     0, 0, 1, 3'b010, 32'h10,  32'h0,        32'h80223344, 32'h0,        0, 0);
        foreach (vq[i]) begin
            access(vq[i].ir, vq[i].we, vq[i].iord, vq[i].sz, vq[i].a, vq[i].wd);
            model(vq[i].ir, vq[i].we, vq[i].sz, vq[i].a, vq[i].wd, emis, eoob);
            chk({vq[i].name, "_rdata"}, rdata, vq[i].e_rdata);
            chk({vq[i].name, "_instr"}, instruction, vq[i].e_instr);
            chk({vq[i].name, "_mis"}, misaligned, vq[i].e_mis);
            chk({vq[i].name, "_oob"}, oob, vq[i].e_oob);
        end

        // Reset during WAIT aborts a store and suppresses ack.
        @(posedge clk); #1;
        req = 1'b1; IRWrite = 1'b0; MemWrite = 1'b1; IorD = 1'b1; size = 3'b010;
        alu_out = 32'h10; wdata = 32'hBADC0DE5;
        @(posedge clk); #1;
        req = 1'b0;
        chk("abort_busy_wait", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_rdata", rdata, 32'd0);
        seen = ack;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            seen |= ack;
        end
        chk("abort_no_ack", seen, 1'b0);
        exp_rdata = 32'd0;
        exp_instr = 32'd0;
        access(1'b0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
        model(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, emis, eoob);
        chk("abort_word_kept", rdata, 32'h80223344);

        // Random accesses against the model.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(MEMB, MEMB + 63));
            else                           a = 32'($urandom_range(0, MEMB - 1));
            rand_op($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
                    3'($urandom_range(0, 7)), a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
